// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared state encoding and default widths for the memory read arbiter
package mem_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// rtl/mem_read_arbiter_rr_pick.sv - combinational round-robin selector
// Picks the first set req bit after 'last', wrapping from NREQ-1 to 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    any    = |req;
    // First pass covers indices above the pointer, second pass wraps around.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one level-handshaked memory read port
// IDLE grants a requester, READ waits for data_ready or timeout, DONE waits for data_ready to drop.
module mem_read_arbiter
  import mem_rd_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    grant,
  output logic [DW-1:0]      rd_data,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ-1:0]    rd_err,
  output logic               busy,
  output logic               mem_read,
  output logic [AW-1:0]      mem_addr,
  input  logic               data_ready,
  input  logic [DW-1:0]      data_bus
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [LW-1:0]   last;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] winner;
  logic            any;
  logic [LW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx  = LW'(i);
        win_addr = req_addr[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      rd_err   <= '0;
      busy     <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      last     <= LW'(NREQ - 1);
      cnt      <= '0;
    end else begin
      rd_valid <= '0;
      rd_err   <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            grant    <= winner;
            mem_addr <= win_addr;
            mem_read <= 1'b1;
            cnt      <= '0;
            last     <= win_idx;
            busy     <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          // Data arriving on the timeout edge still counts as a success.
          if (data_ready) begin
            rd_data  <= data_bus;
            rd_valid <= grant;
            mem_read <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rd_err   <= grant;
            mem_read <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (!data_ready) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          grant    <= '0;
          busy     <= 1'b0;
          mem_read <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - scoreboard testbench for mem_read_arbiter
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_addr;
  logic [1:0]  grant;
  logic [7:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_err;
  logic        busy;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic        data_ready;
  logic [7:0]  data_bus;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] v;
    logic [1:0] e;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];

  mem_read_arbiter #(.NREQ(2), .DW(8), .AW(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .grant      (grant),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .busy       (busy),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .data_ready (data_ready),
    .data_bus   (data_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rd_valid != 2'b00 || rd_err != 2'b00) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: rd_valid=%b rd_err=%b rd_data=%h, none expected", rd_valid, rd_err, rd_data);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        if (grant !== x.g || rd_valid !== x.v || rd_err !== x.e || rd_data !== x.d) begin
          errors++;
          $display("FAIL response: got grant=%b valid=%b err=%b data=%h, expected grant=%b valid=%b err=%b data=%h",
                   grant, rd_valid, rd_err, rd_data, x.g, x.v, x.e, x.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input logic [7:0] a);
    int n;
    n = 0;
    while (!mem_read && n < 20) begin
      tick();
      n++;
    end
    chk("mem_read_rise", 32'(mem_read), 32'd1);
    chk("grant", 32'(grant), 32'(g));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("busy_read", 32'(busy), 32'd1);
  endtask

  task automatic respond(input logic [1:0] g, input logic [7:0] a, input int wait_c,
                         input logic [7:0] d, input int hold,
                         input logic [1:0] drop, input logic [1:0] add);
    exp_t x;
    repeat (wait_c) begin
      tick();
      chk("mem_read_held", 32'(mem_read), 32'd1);
      chk("mem_addr_stable", 32'(mem_addr), 32'(a));
    end
    data_ready = 1'b1;
    data_bus   = d;
    x.g = g; x.v = g; x.e = 2'b00; x.d = d;
    sbq.push_back(x);
    tick();
    chk("mem_read_drop", 32'(mem_read), 32'd0);
    req = (req & ~drop) | add;
    repeat (hold) begin
      tick();
      chk("hold_grant", 32'(grant), 32'(g));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_mem_read", 32'(mem_read), 32'd0);
    end
    data_ready = 1'b0;
    tick();
    chk("done_grant_clr", 32'(grant), 32'd0);
    chk("done_busy_clr", 32'(busy), 32'd0);
  endtask

  task automatic serve(input logic [1:0] g, input logic [7:0] a, input int wait_c,
                       input logic [7:0] d, input int hold,
                       input logic [1:0] drop, input logic [1:0] add);
    wait_grant(g, a);
    respond(g, a, wait_c, d, hold, drop, add);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = 2'b00;
    data_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    exp_t x;
    req_addr = {8'h20, 8'h10};
    data_bus = 8'h00;
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // single request
    req = 2'b01;
    serve(2'b01, 8'h10, 5, 8'hDE, 0, 2'b01, 2'b00);

    // contention, pointer restarted
    do_reset();
    req_addr = {8'hA1, 8'hA0};
    req = 2'b11;
    serve(2'b01, 8'hA0, 2, 8'hDE, 0, 2'b00, 2'b00);
    serve(2'b10, 8'hA1, 2, 8'hAD, 0, 2'b00, 2'b00);
    serve(2'b01, 8'hA0, 2, 8'h5A, 0, 2'b11, 2'b00);

    // four-phase hold with a new request arriving during DONE
    req = 2'b01;
    serve(2'b01, 8'hA0, 1, 8'h33, 4, 2'b01, 2'b10);
    serve(2'b10, 8'hA1, 1, 8'h77, 0, 2'b10, 2'b00);

    // timeout
    req = 2'b10;
    wait_grant(2'b10, 8'hA1);
    repeat (14) begin
      tick();
      chk("to_no_err_yet", 32'(rd_err), 32'd0);
      chk("to_mem_read", 32'(mem_read), 32'd1);
    end
    x.g = 2'b10; x.v = 2'b00; x.e = 2'b10; x.d = 8'h77;
    sbq.push_back(x);
    tick();
    chk("to_mem_read_drop", 32'(mem_read), 32'd0);
    chk("to_rd_data_hold", 32'(rd_data), 32'h77);
    req = 2'b00;
    tick();
    chk("to_busy_clr", 32'(busy), 32'd0);
    chk("to_grant_clr", 32'(grant), 32'd0);

    // data_ready on the same edge the timeout would fire
    req = 2'b01;
    serve(2'b01, 8'hA0, 14, 8'h3C, 0, 2'b01, 2'b00);

    // reset mid-read
    req = 2'b11;
    wait_grant(2'b10, 8'hA1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_mem_read", 32'(mem_read), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mrst_rd_err", 32'(rd_err), 32'd0);
    rst = 1'b0;
    wait_grant(2'b01, 8'hA0);
    respond(2'b01, 8'hA0, 1, 8'h99, 0, 2'b11, 2'b00);

    // data_ready while idle is ignored
    data_ready = 1'b1;
    data_bus   = 8'hFF;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rd_data", 32'(rd_data), 32'h99);
    chk("idle_mem_read", 32'(mem_read), 32'd0);
    data_ready = 1'b0;
    tick();
    tick();

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
